// File: rtl/ucode_sequencer_if.sv
// Bus bundle between a host/ROM/datapath side (master) and the microcode
// sequencer (slave). Parameters must match those of the sequencer instance.
interface ucode_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int STACK_N = 4
);
  localparam int SP_W = $clog2(STACK_N) + 1;

  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            abort;
  logic            rom_en;
  logic [PC_W-1:0] rom_addr;
  logic [2:0]      op_kind;
  logic [1:0]      op_cc;
  logic [PC_W-1:0] op_target;
  logic            flag_z;
  logic            flag_n;
  logic            resume;
  logic            busy;
  logic            done;
  logic            error;
  logic [1:0]      err_code;
  logic [SP_W-1:0] sp;

  modport master (
    output start, start_pc, abort, op_kind, op_cc, op_target,
           flag_z, flag_n, resume,
    input  rom_en, rom_addr, busy, done, error, err_code, sp
  );

  modport slave (
    input  start, start_pc, abort, op_kind, op_cc, op_target,
           flag_z, flag_n, resume,
    output rom_en, rom_addr, busy, done, error, err_code, sp
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetches instructions from an external ROM (1-cycle
// read latency), executes branch/call/return/wait/halt with a small return
// stack, and reports completion and sticky errors.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | not running; waits for start
// FETCH | rom_en high, rom_addr = pc; ROM data returns next cycle
// EXEC  | op_* valid; choose next pc, update stack, retire
// WAIT  | parked after a WAIT op until resume
//
// All outputs are registered. done is raised on the edge that retires HALT,
// so it is visible in the first IDLE cycle after that HALT's EXEC cycle,
// together with busy=0.
module ucode_sequencer #(
  parameter int PC_W    = 8,
  parameter int STACK_N = 4
) (
  input  logic          clk,
  input  logic          rst,
  ucode_sequencer_if.slave bus
);

  localparam int SP_W  = $clog2(STACK_N) + 1;
  localparam int IDX_W = (STACK_N > 1) ? $clog2(STACK_N) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_N);

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JCC  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_UNF = 2'd2;
  localparam logic [1:0] ERR_OP  = 2'd3;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WAIT} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] stack [DEPTH];
  logic [PC_W-1:0] top_val;
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_dec;
  logic            cc_true;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic [1:0]      err_code_q;
  logic            rom_en_q;

  assign pc_inc  = pc + PC_W'(1);
  assign sp_dec  = sp_q - SP_W'(1);
  assign top_val = stack[sp_dec[IDX_W-1:0]];

  // Evaluate the branch condition from the registered datapath flags.
  always_comb begin
    cc_true = 1'b1;
    unique case (bus.op_cc)
      2'd0: cc_true = 1'b1;
      2'd1: cc_true = bus.flag_z;
      2'd2: cc_true = !bus.flag_z && !bus.flag_n;
      2'd3: cc_true = bus.flag_z || bus.flag_n;
      default: cc_true = 1'b1;
    endcase
  end

  // Sequencer FSM, program counter, return stack and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      sp_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      rom_en_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // abort beats start/resume/exec; error status is left as is
        state    <= IDLE;
        sp_q     <= '0;
        busy_q   <= 1'b0;
        rom_en_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              pc         <= bus.start_pc;
              sp_q       <= '0;
              error_q    <= 1'b0;
              err_code_q <= 2'd0;
              state      <= FETCH;
              busy_q     <= 1'b1;
              rom_en_q   <= 1'b1;
            end
          end
          FETCH: begin
            state    <= EXEC;
            rom_en_q <= 1'b0;
          end
          EXEC: begin
            // default: continue with the next fetch
            state    <= FETCH;
            rom_en_q <= 1'b1;
            unique case (bus.op_kind)
              OP_NEXT: pc <= pc_inc;
              OP_JCC:  pc <= cc_true ? bus.op_target : pc_inc;
              OP_CALL: begin
                if (sp_q != SP_FULL) begin
                  stack[sp_q[IDX_W-1:0]] <= pc_inc;
                  sp_q <= sp_q + SP_W'(1);
                  pc   <= bus.op_target;
                end else begin
                  error_q    <= 1'b1;
                  err_code_q <= ERR_OVF;
                  state      <= IDLE;
                  busy_q     <= 1'b0;
                  rom_en_q   <= 1'b0;
                end
              end
              OP_RET: begin
                if (sp_q != '0) begin
                  pc   <= top_val;
                  sp_q <= sp_dec;
                end else begin
                  error_q    <= 1'b1;
                  err_code_q <= ERR_UNF;
                  state      <= IDLE;
                  busy_q     <= 1'b0;
                  rom_en_q   <= 1'b0;
                end
              end
              OP_WAIT: begin
                pc       <= pc_inc;
                state    <= WAIT;
                rom_en_q <= 1'b0;
              end
              OP_HALT: begin
                done_q   <= 1'b1;
                state    <= IDLE;
                busy_q   <= 1'b0;
                rom_en_q <= 1'b0;
              end
              default: begin
                error_q    <= 1'b1;
                err_code_q <= ERR_OP;
                state      <= IDLE;
                busy_q     <= 1'b0;
                rom_en_q   <= 1'b0;
              end
            endcase
          end
          WAIT: begin
            if (bus.resume) begin
              state    <= FETCH;
              rom_en_q <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            rom_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = pc;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_code_q;
  assign bus.sp       = sp_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Testbench for ucode_sequencer: directed programs for the documented
// scenarios plus randomized ROM programs checked against an
// instruction-level interpreter.
module tb_ucode_sequencer;
  localparam int PC_W    = 8;
  localparam int STACK_N = 4;
  localparam int LIMIT   = 30;
  localparam int MAXC    = 2000;

  logic clk = 1'b0;
  logic rst;

  ucode_sequencer_if #(.PC_W(PC_W), .STACK_N(STACK_N)) bus ();

  ucode_sequencer #(.PC_W(PC_W), .STACK_N(STACK_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // instruction ROM contents
  logic [2:0] rom_kind [256];
  logic [1:0] rom_cc   [256];
  logic [7:0] rom_tgt  [256];

  // observations from one run
  logic [7:0] obs_addr [$];
  int         obs_sp   [$];
  int         obs_cyc  [$];
  int         n_done;
  int         done_cyc;
  bit         timed_out;

  // interpreter expectations
  logic [7:0] exp_addr [$];
  int         exp_sp   [$];
  bit         exp_done;
  bit         exp_err;
  int         exp_code;
  int         exp_sp_end;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) begin
      rom_kind[a] = 3'd5;
      rom_cc[a]   = 2'd0;
      rom_tgt[a]  = 8'd0;
    end
  endtask

  task automatic set_op(input logic [7:0] a, input logic [2:0] k,
                        input logic [1:0] c, input logic [7:0] t);
    rom_kind[a] = k;
    rom_cc[a]   = c;
    rom_tgt[a]  = t;
  endtask

  // Instruction-level interpreter: list of fetched addresses with the stack
  // depth at each fetch, and the way the program ends. A program still
  // running at its LIMIT-th fetch is aborted there by the bench.
  task automatic model_run(input logic [7:0] spc, input logic fz, input logic fn);
    logic [7:0] pc;
    logic [7:0] nxt;
    logic [7:0] stk [$];
    bit         cond;
    exp_addr.delete();
    exp_sp.delete();
    exp_done = 0; exp_err = 0; exp_code = 0; exp_sp_end = 0;
    pc = spc;
    for (int i = 0; i < LIMIT; i++) begin
      exp_addr.push_back(pc);
      exp_sp.push_back(stk.size());
      if (i == LIMIT - 1) begin
        exp_sp_end = 0;
        return;
      end
      nxt = pc + 8'd1;
      case (rom_kind[pc])
        3'd0: pc = nxt;
        3'd1: begin
          case (rom_cc[pc])
            2'd0: cond = 1;
            2'd1: cond = fz;
            2'd2: cond = !fz && !fn;
            default: cond = fz || fn;
          endcase
          pc = cond ? rom_tgt[pc] : nxt;
        end
        3'd2: begin
          if (stk.size() == STACK_N) begin
            exp_err = 1; exp_code = 1; exp_sp_end = STACK_N;
            return;
          end
          stk.push_back(nxt);
          pc = rom_tgt[pc];
        end
        3'd3: begin
          if (stk.size() == 0) begin
            exp_err = 1; exp_code = 2; exp_sp_end = 0;
            return;
          end
          pc = stk.pop_back();
        end
        3'd4: pc = nxt;
        3'd5: begin
          exp_done = 1; exp_sp_end = stk.size();
          return;
        end
        default: begin
          exp_err = 1; exp_code = 3; exp_sp_end = stk.size();
          return;
        end
      endcase
    end
  endtask

  // Start a program and service the ROM until the sequencer goes idle.
  // cyc counts negedges after the edge that accepted start.
  task automatic run_prog(input logic [7:0] spc, input logic fz, input logic fn,
                          input int resume_at, input int abort_at, input int rst_at,
                          input bit noise);
    obs_addr.delete(); obs_sp.delete(); obs_cyc.delete();
    n_done = 0; done_cyc = -1; timed_out = 1;
    @(negedge clk);
    bus.flag_z   = fz;
    bus.flag_n   = fn;
    bus.start    = 1'b1;
    bus.start_pc = spc;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.rom_en === 1'b1) begin
        obs_addr.push_back(bus.rom_addr);
        obs_sp.push_back(int'(bus.sp));
        obs_cyc.push_back(cyc);
        bus.op_kind   = rom_kind[bus.rom_addr];
        bus.op_cc     = rom_cc[bus.rom_addr];
        bus.op_target = rom_tgt[bus.rom_addr];
      end
      if (bus.busy !== 1'b1) begin
        timed_out = 0;
        break;
      end
      rst          = (cyc == rst_at);
      bus.abort    = (cyc == abort_at) || (bus.rom_en === 1'b1 && obs_addr.size() == LIMIT);
      bus.start    = noise && ($urandom_range(9) == 0);
      bus.start_pc = 8'($urandom);
      bus.resume   = (resume_at < 0) ? ($urandom_range(2) == 0) : (cyc == resume_at);
    end
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.resume = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_len"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
      chk($sformatf("%s_sp%0d", tag, i), obs_sp[i], exp_sp[i]);
    end
    chk({tag, "_done"}, n_done, exp_done ? 1 : 0);
    chk({tag, "_error"}, bus.error, exp_err);
    chk({tag, "_code"}, bus.err_code, exp_code);
    chk({tag, "_spend"}, bus.sp, exp_sp_end);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.start_pc = 0; bus.abort = 0; bus.resume = 0;
    bus.op_kind = 0; bus.op_cc = 0; bus.op_target = 0;
    bus.flag_z = 0; bus.flag_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_code", bus.err_code, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_sp", bus.sp, 0);
    chk("rst_pc", bus.rom_addr, 0);
    rst = 1'b0;

    // straight-line program: fetch timing and done latency
    fill_halt();
    set_op(8'h10, 3'd0, 2'd0, 8'h00);
    set_op(8'h11, 3'd0, 2'd0, 8'h00);
    model_run(8'h10, 0, 0);
    run_prog(8'h10, 0, 0, -1, -1, -1, 1);
    compare_model("seq");
    chk("seq_fetch_cyc1", obs_cyc.size() > 1 ? obs_cyc[1] : -1, 2);
    chk("seq_fetch_cyc2", obs_cyc.size() > 2 ? obs_cyc[2] : -1, 4);
    chk("seq_done_cyc", done_cyc, 6);
    chk("seq_busy_at_done", bus.busy, 0);
    @(negedge clk);
    chk("seq_done_pulse", bus.done, 0);

    // conditional jump
    fill_halt();
    set_op(8'h05, 3'd1, 2'd1, 8'h40);
    model_run(8'h05, 1, 0);
    run_prog(8'h05, 1, 0, -1, -1, -1, 0);
    compare_model("jeq_t");
    chk("jeq_t_target", obs_addr.size() > 1 ? obs_addr[1] : 0, 8'h40);
    model_run(8'h05, 0, 0);
    run_prog(8'h05, 0, 0, -1, -1, -1, 0);
    compare_model("jeq_f");
    chk("jeq_f_target", obs_addr.size() > 1 ? obs_addr[1] : 0, 8'h06);
    set_op(8'h05, 3'd1, 2'd3, 8'h40);
    run_prog(8'h05, 0, 1, -1, -1, -1, 0);
    chk("jle_target", obs_addr.size() > 1 ? obs_addr[1] : 0, 8'h40);

    // five nested calls overflow a 4-deep stack
    fill_halt();
    set_op(8'h30, 3'd2, 2'd2, 8'h50);
    set_op(8'h50, 3'd2, 2'd0, 8'h60);
    set_op(8'h60, 3'd2, 2'd1, 8'h70);
    set_op(8'h70, 3'd2, 2'd3, 8'h80);
    set_op(8'h80, 3'd2, 2'd0, 8'h90);
    model_run(8'h30, 0, 0);
    run_prog(8'h30, 0, 0, -1, -1, -1, 0);
    compare_model("ovf");
    chk("ovf_error", bus.error, 1);
    chk("ovf_code", bus.err_code, 1);
    chk("ovf_busy", bus.busy, 0);
    chk("ovf_sp", bus.sp, 4);
    // abort while idle clears sp and keeps the error
    @(negedge clk); bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    chk("idle_abort_sp", bus.sp, 0);
    chk("idle_abort_err", bus.error, 1);
    chk("idle_abort_code", bus.err_code, 1);

    // four calls then four returns
    fill_halt();
    set_op(8'hA0, 3'd2, 2'd0, 8'hB0);
    set_op(8'hB0, 3'd2, 2'd0, 8'hC0);
    set_op(8'hC0, 3'd2, 2'd0, 8'hD0);
    set_op(8'hD0, 3'd2, 2'd0, 8'hE0);
    set_op(8'hE0, 3'd3, 2'd0, 8'h00);
    set_op(8'hD1, 3'd3, 2'd0, 8'h00);
    set_op(8'hC1, 3'd3, 2'd0, 8'h00);
    set_op(8'hB1, 3'd3, 2'd0, 8'h00);
    model_run(8'hA0, 0, 0);
    run_prog(8'hA0, 0, 0, -1, -1, -1, 0);
    compare_model("callret");
    chk("callret_last", obs_addr.size() > 0 ? obs_addr[obs_addr.size()-1] : 0, 8'hA1);
    chk("callret_start_clears", bus.error, 0);

    // underflow and invalid op; error is sticky while idle
    fill_halt();
    set_op(8'h02, 3'd3, 2'd0, 8'h00);
    set_op(8'h03, 3'd7, 2'd0, 8'h00);
    run_prog(8'h02, 0, 0, -1, -1, -1, 0);
    chk("unf_error", bus.error, 1);
    chk("unf_code", bus.err_code, 2);
    run_prog(8'h03, 0, 0, -1, -1, -1, 0);
    chk("inv_code", bus.err_code, 3);
    chk("inv_done", n_done, 0);
    repeat (4) @(negedge clk);
    chk("inv_sticky_err", bus.error, 1);
    chk("inv_sticky_code", bus.err_code, 3);
    run_prog(8'h04, 0, 0, -1, -1, -1, 0);
    chk("clear_error", bus.error, 0);
    chk("clear_code", bus.err_code, 0);

    // pc wraps from 0xFF to 0x00
    fill_halt();
    set_op(8'hFF, 3'd0, 2'd0, 8'h00);
    model_run(8'hFF, 0, 0);
    run_prog(8'hFF, 0, 0, -1, -1, -1, 0);
    compare_model("wrap");

    // WAIT held 10 cycles then resumed
    fill_halt();
    set_op(8'h20, 3'd4, 2'd0, 8'h00);
    run_prog(8'h20, 0, 0, 11, -1, -1, 0);
    chk("wait_addr", obs_addr.size() > 1 ? obs_addr[1] : 0, 8'h21);
    chk("wait_fetch_cyc", obs_cyc.size() > 1 ? obs_cyc[1] : -1, 12);
    chk("wait_done", n_done, 1);

    // abort and reset while parked in WAIT with one stack entry
    fill_halt();
    set_op(8'h20, 3'd2, 2'd0, 8'h28);
    set_op(8'h28, 3'd4, 2'd0, 8'h00);
    run_prog(8'h20, 0, 0, 9999, 8, -1, 0);
    chk("wabort_timeout", timed_out, 0);
    chk("wabort_sp_before", obs_sp.size() > 1 ? obs_sp[1] : -1, 1);
    chk("wabort_busy", bus.busy, 0);
    chk("wabort_sp", bus.sp, 0);
    chk("wabort_done", n_done, 0);
    chk("wabort_err", bus.error, 0);
    run_prog(8'h20, 0, 0, 9999, -1, 8, 0);
    chk("wrst_timeout", timed_out, 0);
    chk("wrst_busy", bus.busy, 0);
    chk("wrst_sp", bus.sp, 0);
    chk("wrst_pc", bus.rom_addr, 0);
    chk("wrst_rom_en", bus.rom_en, 0);
    chk("wrst_done", n_done, 0);

    // randomized programs
    for (int r = 0; r < 40; r++) begin
      logic [7:0] spc;
      logic       fz;
      logic       fn;
      for (int a = 0; a < 256; a++) begin
        int p;
        p = $urandom_range(99);
        if (p < 30)      rom_kind[a] = 3'd0;
        else if (p < 50) rom_kind[a] = 3'd1;
        else if (p < 65) rom_kind[a] = 3'd2;
        else if (p < 80) rom_kind[a] = 3'd3;
        else if (p < 88) rom_kind[a] = 3'd4;
        else if (p < 95) rom_kind[a] = 3'd5;
        else             rom_kind[a] = 3'($urandom_range(7, 6));
        rom_cc[a]  = 2'($urandom);
        rom_tgt[a] = 8'($urandom);
      end
      spc = 8'($urandom);
      fz  = 1'($urandom);
      fn  = 1'($urandom);
      model_run(spc, fz, fn);
      run_prog(spc, fz, fn, -1, -1, -1, 1);
      compare_model($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, program-counter width in bits.
REQ-002 The block SHALL have parameter STACK_N, default 4, call/return stack depth in entries (>=1).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, single-cycle request to begin execution at start_pc.
REQ-006 The block SHALL have port start_pc, input, PC_W, entry address sampled with start.
REQ-007 The block SHALL have port abort, input, 1, forces return to IDLE.
REQ-008 The block SHALL have port rom_en, output, 1, instruction ROM read strobe.
REQ-009 The block SHALL have port rom_addr, output, PC_W, ROM address (equals pc); data returns with 1-cycle latency.
REQ-010 The block SHALL have port op_kind, input, 3, decoded operation: 0 NEXT, 1 JCC, 2 CALL, 3 RET, 4 WAIT, 5 HALT, 6-7 invalid.
REQ-011 The block SHALL have port op_cc, input, 2, condition: 0 UNCOND, 1 EQ, 2 GT, 3 LE.
REQ-012 The block SHALL have port op_target, input, PC_W, jump/call target.
REQ-013 The block SHALL have ports flag_z and flag_n, input, 1 each, registered datapath flags.
REQ-014 The block SHALL have port resume, input, 1, releases WAIT.
REQ-015 The block SHALL have port busy, output, 1, high in any state except IDLE.
REQ-016 The block SHALL have port done, output, 1, one-cycle pulse on HALT retire.
REQ-017 The block SHALL have port error, output, 1, sticky until next accepted start or rst.
REQ-018 The block SHALL have port err_code, output, 2: 0 none, 1 stack overflow, 2 stack underflow, 3 invalid op.
REQ-019 The block SHALL have port sp, output, clog2(STACK_N)+1, current stack occupancy.

Function
REQ-020 States SHALL be IDLE, FETCH, EXEC, WAIT; each instruction takes exactly 2 cycles (FETCH then EXEC) absent WAIT.
REQ-021 IDLE: start=1 SHALL load pc<=start_pc, sp<=0, error<=0, err_code<=0, go FETCH; start outside IDLE SHALL be ignored.
REQ-022 FETCH: rom_en=1, rom_addr=pc, next state EXEC; rom_en SHALL be 0 in all other states.
REQ-023 EXEC: op_* SHALL be sampled and next pc chosen; NEXT: pc<=pc+1, go FETCH.
REQ-024 pc+1 SHALL wrap modulo 2^PC_W (max address -> 0) without error.
REQ-025 JCC: condition true SHALL give pc<=op_target, else pc<=pc+1; EQ=flag_z, GT=!flag_z&&!flag_n, LE=flag_z||flag_n, UNCOND=1.
REQ-026 CALL (op_cc ignored): sp<STACK_N SHALL push pc+1, sp<=sp+1, pc<=op_target; sp==STACK_N SHALL set error, err_code=1, go IDLE, stack unchanged.
REQ-027 RET: sp>0 SHALL pop, pc<=popped value, sp<=sp-1; sp==0 SHALL set error, err_code=2, go IDLE.
REQ-028 WAIT: pc<=pc+1, go WAIT; WAIT SHALL go FETCH on the first cycle resume=1; resume in other states SHALL be ignored.
REQ-029 HALT: done=1 for that EXEC cycle, go IDLE, pc unchanged.
REQ-030 Invalid op (6,7): error, err_code=3, go IDLE, no done.
REQ-031 abort SHALL take priority over all events outside rst: next state IDLE, sp<=0, no done, error unchanged.
REQ-032 Once set, error and err_code SHALL hold until the next accepted start or rst.

Reset
REQ-033 rst=1 SHALL force state IDLE, pc=0, sp=0, busy=0, done=0, error=0, err_code=0, rom_en=0 on the next edge, from any state including mid-WAIT and mid-EXEC.
REQ-034 Stack contents SHALL be don't-care after reset; only sp is reset.

Verification
REQ-035 start, start_pc=0x10, ops NEXT,NEXT,HALT -> rom_addr 0x10,0x11,0x12 on FETCH cycles; done pulses 6 cycles after start; busy=0 next cycle.
REQ-036 JCC EQ target 0x40 at pc 0x05: flag_z=1 -> next rom_addr 0x40; flag_z=0 -> 0x06; LE with flag_n=1, flag_z=0 -> 0x40.
REQ-037 STACK_N=4: five nested CALLs -> sp 1..4, fifth gives error=1, err_code=1, busy=0; four RETs after four CALLs return to each caller+1.
REQ-038 RET with sp=0 -> err_code=2; op_kind=7 -> err_code=3; next start clears error.
REQ-039 PC_W=8, NEXT at pc 0xFF -> next rom_addr 0x00, error=0.
REQ-040 WAIT held 10 cycles, then resume -> FETCH of pc+1; abort or rst during WAIT -> IDLE, sp=0, done never asserted.
